// File: rtl/wb_uart_fifo_if.sv
// Wishbone slave bus bundle for wb_uart_fifo; master drives requests, slave returns data/ack.
interface wb_uart_fifo_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_uart_fifo.sv
// Byte FIFO: push lands on the clock edge, head byte is visible combinationally from the next cycle.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module wb_uart_fifo_buf #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_vld_i,
    input  logic [7:0]    push_dat_i,
    output logic          push_rdy_o,
    output logic          pop_vld_o,
    output logic [7:0]    pop_dat_o,
    input  logic          pop_rdy_i,
    output logic [AW:0]   count_o
);
    localparam int DEPTH = 2 ** AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign pop_vld_o  = (cnt_q != '0);
    assign push_rdy_o = (cnt_q != (AW+1)'(DEPTH));
    assign do_pop     = pop_rdy_i & pop_vld_o;
    assign do_push    = push_vld_i & (push_rdy_o | do_pop);
    assign pop_dat_o  = mem_q[rd_ptr_q];
    assign count_o    = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// Wishbone UART with RX/TX byte FIFOs, programmable divisor and maskable level interrupt.
// Ack one cycle after request, min 2-cycle access spacing; full TX FIFO drops writes, full RX FIFO drops frames.
module wb_uart_fifo #(
    parameter int clk_freq = 100000000,
    parameter int baud     = 115200,
    parameter int fifo_aw  = 4
) (
    input  logic          clk,
    input  logic          reset,
    wb_uart_fifo_if.slave wb,
    output logic          intr,
    input  logic          uart_rxd,
    output logic          uart_txd
);
    localparam logic [15:0] DIV_RST = 16'(clk_freq / baud - 1);
    localparam logic [15:0] DIV_MIN = 16'd15;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    // ---------------- bus side ----------------
    logic        ack_q, ack_d;
    logic [31:0] rdat_q, rdat_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  ier_q, ier_d;
    logic        ovr_q, ovr_d, ferr_q, ferr_d, drop_q, drop_d;
    logic        intr_q, intr_d;

    logic        req, acc, acc_rd, acc_wr, stat_rd;
    logic [1:0]  reg_sel;
    logic [31:0] stat;
    logic        tx_idle, err_any;
    logic        ovr_evt, drop_evt;

    logic        rxf_push_rdy, rxf_pop_vld, rxf_pop;
    logic [7:0]  rxf_pop_dat;
    logic        txf_push, txf_push_rdy, txf_pop_vld, txf_pop;
    logic [7:0]  txf_pop_dat;
    logic [fifo_aw:0] rxf_count, txf_count;

    logic        rx_push_q, rx_ferr_q;
    logic [7:0]  rx_sh_q;

    logic        unused_bits;
    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                           wb.wb_dat_i[31:16], rxf_count, txf_count};

    assign req     = wb.wb_stb_i & wb.wb_cyc_i;
    assign acc     = req & ~ack_q;
    assign acc_rd  = acc & ~wb.wb_we_i;
    assign acc_wr  = acc & wb.wb_we_i;
    assign reg_sel = wb.wb_adr_i[3:2];
    assign stat_rd = acc_rd & (reg_sel == 2'd0);
    assign rxf_pop = acc_rd & (reg_sel == 2'd1);
    assign txf_push = acc_wr & (reg_sel == 2'd1);

    // A pop in the same cycle frees the slot, so only a blocked push counts as a loss.
    assign ovr_evt  = rx_push_q & ~rxf_push_rdy & ~rxf_pop;
    assign drop_evt = txf_push & ~txf_push_rdy & ~txf_pop;
    assign err_any  = ovr_q | ferr_q | drop_q;

    assign stat = {25'b0, drop_q, ferr_q, ovr_q, tx_idle,
                   ~txf_push_rdy, ~rxf_push_rdy, rxf_pop_vld};

    always_comb begin
        ack_d  = acc;
        rdat_d = rdat_q;
        div_d  = div_q;
        ier_d  = ier_q;
        if (acc_rd) begin
            case (reg_sel)
                2'd0: rdat_d = stat;
                2'd1: rdat_d = {24'b0, rxf_pop_vld ? rxf_pop_dat : 8'h00};
                2'd2: rdat_d = {16'b0, div_q};
                2'd3: rdat_d = {29'b0, ier_q};
                default: rdat_d = '0;
            endcase
        end
        if (acc_wr) begin
            case (reg_sel)
                2'd2: div_d = (wb.wb_dat_i[15:0] < DIV_MIN) ? DIV_MIN : wb.wb_dat_i[15:0];
                2'd3: ier_d = wb.wb_dat_i[2:0];
                default: ;
            endcase
        end
        ovr_d  = ovr_evt   | (ovr_q  & ~stat_rd);
        ferr_d = rx_ferr_q | (ferr_q & ~stat_rd);
        drop_d = drop_evt  | (drop_q & ~stat_rd);
        intr_d = |(ier_q & {err_any, tx_idle, rxf_pop_vld});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
            div_q  <= DIV_RST;
            ier_q  <= 3'b001;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            drop_q <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            rdat_q <= rdat_d;
            div_q  <= div_d;
            ier_q  <= ier_d;
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
            drop_q <= drop_d;
            intr_q <= intr_d;
        end
    end

    assign wb.wb_ack_o = req & ack_q;
    assign wb.wb_dat_o = rdat_q;
    assign intr        = intr_q;

    // ---------------- FIFOs ----------------
    wb_uart_fifo_buf #(.AW(fifo_aw)) u_rx_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_vld_i (rx_push_q),
        .push_dat_i (rx_sh_q),
        .push_rdy_o (rxf_push_rdy),
        .pop_vld_o  (rxf_pop_vld),
        .pop_dat_o  (rxf_pop_dat),
        .pop_rdy_i  (rxf_pop),
        .count_o    (rxf_count)
    );

    wb_uart_fifo_buf #(.AW(fifo_aw)) u_tx_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_vld_i (txf_push),
        .push_dat_i (wb.wb_dat_i[7:0]),
        .push_rdy_o (txf_push_rdy),
        .pop_vld_o  (txf_pop_vld),
        .pop_dat_o  (txf_pop_dat),
        .pop_rdy_i  (txf_pop),
        .count_o    (txf_count)
    );

    // ---------------- receiver ----------------
    uart_state_t rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rx_line, rx_fall;
    logic [16:0] rx_half;

    assign rx_line = rx_s2_q;
    assign rx_fall = rx_prev_q & ~rx_s2_q;
    assign rx_half = ({1'b0, div_q} + 17'd1) >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= uart_rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            case (rx_state_q)
                ST_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_fall) rx_state_q <= ST_START;
                end
                ST_START: begin
                    // Mid-start-bit check: a line already back high was a glitch.
                    if ({1'b0, rx_cnt_q} == rx_half - 17'd1) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_line ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_q == div_q) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_line, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_q <= ST_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_q == div_q) begin
                        rx_cnt_q   <= '0;
                        rx_push_q  <= rx_line;
                        rx_ferr_q  <= ~rx_line;
                        rx_state_q <= ST_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    uart_state_t tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [15:0] tx_div_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_sh_q;
    logic        txd_q;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == tx_div_q);
    assign txf_pop    = txf_pop_vld & ((tx_state_q == ST_IDLE) |
                                       ((tx_state_q == ST_STOP) & tx_bit_end));
    assign tx_idle    = (tx_state_q == ST_IDLE) & ~txf_pop_vld;
    assign uart_txd   = txd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_RST;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                ST_IDLE: begin
                    tx_cnt_q <= '0;
                    if (txf_pop) begin
                        tx_sh_q    <= txf_pop_dat;
                        tx_div_q   <= div_q;
                        txd_q      <= 1'b0;
                        tx_state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_bit_end) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        txd_q      <= tx_sh_q[0];
                        tx_state_q <= ST_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= ST_STOP;
                        end else begin
                            tx_bit_q <= tx_bit_q + 1'b1;
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                            txd_q    <= tx_sh_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= '0;
                        // Divisor is re-latched per frame so mid-frame DIV writes cannot skew bits.
                        if (txf_pop) begin
                            tx_sh_q    <= txf_pop_dat;
                            tx_div_q   <= div_q;
                            txd_q      <= 1'b0;
                            tx_state_q <= ST_START;
                        end else begin
                            tx_state_q <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_uart_fifo.sv
// Randomized bench for wb_uart_fifo against a queue-based model of the register map and serial line.
module tb_wb_uart_fifo;
    localparam int CLK_FREQ = 100000000;
    localparam int BAUD     = 115200;
    localparam int AW       = 2;
    localparam int DEPTH    = 4;
    localparam int DIV_RST  = CLK_FREQ / BAUD - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic intr, uart_rxd, uart_txd;
    logic rx_drv = 1'b1;
    logic loop = 1'b0;

    wb_uart_fifo_if wb();
    assign uart_rxd = loop ? uart_txd : rx_drv;

    wb_uart_fifo #(.clk_freq(CLK_FREQ), .baud(BAUD), .fifo_aw(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb       (wb),
        .intr     (intr),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;
    int cur_div = DIV_RST;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] mon_q[$];
    bit m_ovr = 0, m_ferr = 0, m_drop = 0;
    bit mon_en = 0;
    int mon_stop_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd);
        int n;
        @(negedge clk);
        wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = we;
        wb.wb_adr_i = a; wb.wb_dat_i = wd; wb.wb_sel_i = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb.wb_ack_o && n < 20);
        if (!wb.wb_ack_o) chk("ack_timeout", {31'b0, wb.wb_ack_o}, 32'd1);
        rd = wb.wb_dat_o;
        wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, dummy);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
        wb_xfer(1'b0, a, 32'h0, d);
    endtask

    function automatic logic [31:0] model_stat(input bit tx_idle, input bit tx_full);
        return {25'b0, m_drop, m_ferr, m_ovr, tx_idle, tx_full,
                rxq.size() == DEPTH, rxq.size() != 0};
    endfunction

    task automatic stat_chk(input string tag, input bit tx_idle, input bit tx_full);
        logic [31:0] d;
        wb_rd(32'h0, d);
        chk(tag, d, model_stat(tx_idle, tx_full));
        m_ovr = 0; m_ferr = 0; m_drop = 0;
    endtask

    task automatic data_chk(input string tag);
        logic [31:0] d, e;
        wb_rd(32'h4, d);
        e = 32'h0;
        if (rxq.size() != 0) e = {24'b0, rxq.pop_front()};
        chk(tag, d, e);
    endtask

    task automatic set_div(input int v);
        wb_wr(32'h8, v);
        cur_div = (v < 15) ? 15 : v;
    endtask

    task automatic rx_model_push(input logic [7:0] b);
        if (rxq.size() < DEPTH) rxq.push_back(b);
        else m_ovr = 1;
    endtask

    task automatic tx_byte(input logic [7:0] b);
        wb_wr(32'h4, {24'b0, b});
        txq.push_back(b);
        if (loop) rx_model_push(b);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        int p;
        p = cur_div + 1;
        rx_drv = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (p) @(negedge clk);
        end
        rx_drv = stop;
        repeat (p) @(negedge clk);
        rx_drv = 1'b1;
        if (!stop) repeat (p) @(negedge clk);
    endtask

    task automatic inject(input logic [7:0] b, input bit stop);
        send_frame(b, stop);
        repeat (4) @(negedge clk);
        if (stop) rx_model_push(b);
        else m_ferr = 1;
    endtask

    // Line monitor: decodes whatever the transmitter sends, sampling mid-bit.
    initial begin : line_mon
        logic [7:0] b;
        int p;
        forever begin
            @(negedge clk);
            if (mon_en && uart_txd === 1'b0) begin
                p = cur_div + 1;
                repeat (p / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (p) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (p) @(negedge clk);
                if (uart_txd !== 1'b1) mon_stop_bad++;
                mon_q.push_back(b);
            end
        end
    end

    task automatic mon_chk(input string tag);
        while (txq.size() != 0) begin
            if (mon_q.size() == 0) begin
                chk({tag, "_missing"}, 32'd0, {24'b0, txq.pop_front()});
            end else begin
                chk(tag, {24'b0, mon_q.pop_front()}, {24'b0, txq.pop_front()});
            end
        end
        chk({tag, "_extra"}, mon_q.size(), 0);
    endtask

    initial begin : main
        logic [31:0] d;
        logic [7:0] a8, b8;
        int v, n;

        wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_txd",  {31'b0, uart_txd}, 32'd1);
        chk("rst_ack",  {31'b0, wb.wb_ack_o}, 32'd0);
        chk("rst_intr", {31'b0, intr}, 32'd0);
        chk("rst_dato", wb.wb_dat_o, 32'd0);
        reset = 1'b0;
        stat_chk("rst_stat", 1, 0);
        wb_rd(32'h8, d); chk("rst_div", d, DIV_RST);
        wb_rd(32'hC, d); chk("rst_ier", d, 32'd1);
        chk("rst_intr2", {31'b0, intr}, 32'd0);

        // tx_idle interrupt source
        wb_wr(32'hC, 32'd2);
        repeat (2) @(negedge clk);
        chk("intr_txidle", {31'b0, intr}, 32'd1);
        wb_wr(32'hC, 32'd1);
        repeat (2) @(negedge clk);
        chk("intr_off", {31'b0, intr}, 32'd0);

        // random register writes, divisor clamp
        for (int i = 0; i < 6; i++) begin
            v = $urandom_range(0, 40);
            set_div(v);
            wb_rd(32'h8, d); chk("div_rw", d, cur_div);
            v = $urandom_range(0, 7);
            wb_wr(32'hC, {$urandom_range(0, 255), 3'(v)});
            wb_rd(32'hC, d); chk("ier_rw", d, v);
        end
        wb_wr(32'hC, 32'd1);

        // directed loopback
        set_div(15);
        loop = 1'b1;
        mon_en = 1'b1;
        tx_byte(8'hA5);
        tx_byte(8'h3C);
        repeat (360) @(negedge clk);
        chk("lb_intr", {31'b0, intr}, 32'd1);
        data_chk("lb_rd0");
        data_chk("lb_rd1");
        stat_chk("lb_stat", 1, 0);
        mon_chk("lb_mon");

        // random loopback rounds
        for (int r = 0; r < 5; r++) begin
            set_div($urandom_range(15, 30));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) tx_byte(8'($urandom));
            repeat (10 * (cur_div + 1) * n + 4 * (cur_div + 1) + 20) @(negedge clk);
            for (int i = 0; i <= n; i++) data_chk("rnd_rd");
            stat_chk("rnd_stat", 1, 0);
            mon_chk("rnd_mon");
        end
        chk("mon_stop", mon_stop_bad, 0);
        mon_en = 1'b0;
        loop = 1'b0;

        // pop coinciding with receiver push, swept across the push cycle
        set_div(15);
        for (int dly = 148; dly < 164; dly++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            inject(a8, 1);
            fork
                inject(b8, 1);
                begin
                    repeat (dly) @(negedge clk);
                    data_chk("sw_rd_a");
                end
            join
            data_chk("sw_rd_b");
            stat_chk("sw_stat", 1, 0);
        end

        // RX overrun
        for (int i = 0; i < 5; i++) inject(8'($urandom), 1);
        stat_chk("ovr_stat", 1, 0);
        for (int i = 0; i < 4; i++) data_chk("ovr_rd");
        stat_chk("ovr_stat2", 1, 0);

        // framing error with error interrupt
        wb_wr(32'hC, 32'd4);
        repeat (2) @(negedge clk);
        chk("fe_intr0", {31'b0, intr}, 32'd0);
        inject(8'($urandom), 0);
        chk("fe_intr1", {31'b0, intr}, 32'd1);
        stat_chk("fe_stat", 1, 0);
        repeat (2) @(negedge clk);
        chk("fe_intr2", {31'b0, intr}, 32'd0);
        wb_wr(32'hC, 32'd1);

        // start-bit glitch
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        stat_chk("glitch_stat", 1, 0);

        // TX FIFO full and drop with a stalled shifter
        set_div(16'hFFFF);
        for (int i = 0; i < 5; i++) wb_wr(32'h4, $urandom_range(0, 255));
        stat_chk("txf_full", 0, 1);
        wb_wr(32'h4, 32'h5A);
        m_drop = 1;
        stat_chk("txf_drop", 0, 1);
        stat_chk("txf_drop_clr", 0, 1);
        chk("txd_start", {31'b0, uart_txd}, 32'd0);

        // reset mid-frame
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_txd", {31'b0, uart_txd}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rxq.delete();
        m_ovr = 0; m_ferr = 0; m_drop = 0;
        cur_div = DIV_RST;
        stat_chk("rst_mid_stat", 1, 0);
        wb_rd(32'h8, d); chk("rst_mid_div", d, DIV_RST);
        data_chk("rst_mid_rd");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
